// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc -- multi-cycle execute-stage ALU.
//
// ADD, SUB, AND and OR finish in one cycle. MUL runs on an iterative
// shift-add engine for WIDTH cycles, and busy_o stalls the pipeline while it
// runs. The result and zero flag are registered for the EX/MEM boundary.
//
// Ports
//   clk_i      rising-edge clock
//   rst_i      asynchronous, active-low reset
//   start_i    operation request, qualified with ALUCtrl_i and both operands
//   flush_i    aborts any in-flight operation; wins over start_i
//   ALUCtrl_i  000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101-111 -> 0
//   data1_i    operand A
//   data2_i    operand B
//   data_o     registered result; holds its value between results
//   zero_o     registered (data_o == 0)
//   valid_o    one-cycle pulse marking a new result
//   busy_o     combinational stall request to the hazard unit
// ---------------------------------------------------------------------------
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             flush_i,
  input  logic [2:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic [WIDTH-1:0] data_o,
  output logic             zero_o,
  output logic             valid_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] mcand_q;   // multiplicand, shifted left each iteration
  logic [WIDTH-1:0] mplier_q;  // multiplier, shifted right each iteration
  logic [WIDTH-1:0] acc_q;     // partial product
  logic [CW-1:0]    cnt_q;     // completed iterations
  logic [WIDTH-1:0] data_q;
  logic             zero_q;
  logic             valid_q;

  logic [WIDTH-1:0] alu_d;     // single-cycle result
  logic [WIDTH-1:0] acc_d;     // partial product after this iteration
  logic             last_iter;

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    alu_d = '0;
    case (ALUCtrl_i)
      OP_ADD:  alu_d = data1_i + data2_i;
      OP_SUB:  alu_d = data1_i - data2_i;
      OP_AND:  alu_d = data1_i & data2_i;
      OP_OR:   alu_d = data1_i | data2_i;
      default: alu_d = '0;  // undefined codes produce 0; MUL never uses alu_d
    endcase
  end

  // Low WIDTH bits of the product are the same for signed and unsigned
  // operands, so the engine is purely unsigned and wraps modulo 2^WIDTH.
  assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      data_q   <= '0;
      zero_q   <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (flush_i) begin
        // Drop the in-flight MUL and any same-cycle request; keep data/zero.
        state_q <= IDLE;
      end else begin
        case (state_q)
          IDLE: begin
            if (start_i) begin
              if (ALUCtrl_i == OP_MUL) begin
                mcand_q  <= data1_i;
                mplier_q <= data2_i;
                acc_q    <= '0;
                cnt_q    <= '0;
                state_q  <= RUN;
              end else begin
                data_q  <= alu_d;
                zero_q  <= (alu_d == '0);
                valid_q <= 1'b1;
              end
            end
          end
          RUN: begin
            // start_i is ignored here; upstream holds while busy_o is high.
            acc_q    <= acc_d;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (last_iter) begin
              data_q  <= acc_d;
              zero_q  <= (acc_d == '0);
              valid_q <= 1'b1;
              state_q <= IDLE;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Stall is raised in the MUL acceptance cycle itself so the upstream stage
  // holds from the very first cycle; it drops in the cycle valid_o rises.
  assign busy_o = (state_q == RUN) ||
                  ((state_q == IDLE) && start_i && (ALUCtrl_i == OP_MUL) && !flush_i);

  assign data_o  = data_q;
  assign zero_o  = zero_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_alu_mc.sv
// ---------------------------------------------------------------------------
// tb_alu_mc -- directed self-checking bench for alu_mc (WIDTH = 32).
// Inputs are driven and outputs sampled 1 ns after each rising edge, so a
// "cycle" is the interval that starts at that edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_mc;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic        flush_i;
  logic [2:0]  ALUCtrl_i;
  logic [31:0] data1_i;
  logic [31:0] data2_i;
  logic [31:0] data_o;
  logic        zero_o;
  logic        valid_o;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;

  alu_mc #(.WIDTH(32)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .start_i   (start_i),
    .flush_i   (flush_i),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .data_o    (data_o),
    .zero_o    (zero_o),
    .valid_o   (valid_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Advance to 1 ns after the next rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic st, input logic [2:0] op,
                       input logic [31:0] a, input logic [31:0] b);
    start_i   = st;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
  endtask

  // Full MUL: accepted in cycle 0, result expected in cycle 33.
  task automatic do_mul(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    drive(1'b1, 3'b100, a, b);
    #1;
    check({tag, " busy c0"}, {31'd0, busy_o}, 32'd1);
    tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    repeat (31) tick();
    #1;
    check({tag, " busy c32"}, {31'd0, busy_o}, 32'd1);
    check({tag, " valid c32"}, {31'd0, valid_o}, 32'd0);
    tick();
    check({tag, " data"},  data_o, exp);
    check({tag, " zero"},  {31'd0, zero_o}, {31'd0, exp == 32'd0});
    check({tag, " valid"}, {31'd0, valid_o}, 32'd1);
    check({tag, " busy c33"}, {31'd0, busy_o}, 32'd0);
    tick();
  endtask

  initial begin
    int busy_lo;
    int valid_hi;

    rst_i   = 1'b0;
    flush_i = 1'b0;
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    repeat (3) tick();
    check("rst data",  data_o, 32'd0);
    check("rst zero",  {31'd0, zero_o}, 32'd1);
    check("rst valid", {31'd0, valid_o}, 32'd0);
    check("rst busy",  {31'd0, busy_o}, 32'd0);
    rst_i = 1'b1;

    // ---- Reset then ADD ----
    drive(1'b1, 3'b000, 32'd5, 32'd7);
    tick();
    check("add data",  data_o, 32'd12);
    check("add valid", {31'd0, valid_o}, 32'd1);
    check("add zero",  {31'd0, zero_o}, 32'd0);
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    tick();
    check("add valid drop", {31'd0, valid_o}, 32'd0);
    check("add data hold",  data_o, 32'd12);

    // ---- SUB / SUB / AND / OR back-to-back ----
    drive(1'b1, 3'b001, 32'd7, 32'd7);
    tick();
    check("sub0 data",  data_o, 32'd0);
    check("sub0 zero",  {31'd0, zero_o}, 32'd1);
    check("sub0 valid", {31'd0, valid_o}, 32'd1);
    drive(1'b1, 3'b001, 32'd0, 32'd1);
    tick();
    check("subw data",  data_o, 32'hFFFF_FFFF);
    check("subw zero",  {31'd0, zero_o}, 32'd0);
    check("subw valid", {31'd0, valid_o}, 32'd1);
    drive(1'b1, 3'b010, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    tick();
    check("and data",  data_o, 32'h00F0_00F0);
    check("and valid", {31'd0, valid_o}, 32'd1);
    drive(1'b1, 3'b011, 32'hF0F0_F0F0, 32'h0FF0_0FF0);
    tick();
    check("or data",  data_o, 32'hFFF0_FFF0);
    check("or valid", {31'd0, valid_o}, 32'd1);
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    tick();
    check("b2b valid drop", {31'd0, valid_o}, 32'd0);

    // ---- MUL latency with ignored start pulses in cycles 5-20 ----
    drive(1'b1, 3'b100, 32'h0001_2345, 32'h0000_0100);
    #1;
    check("mul busy c0", {31'd0, busy_o}, 32'd1);
    busy_lo  = 0;
    valid_hi = 0;
    for (int c = 1; c <= 32; c++) begin
      tick();
      if (c >= 5 && c <= 20) drive(1'b1, 3'b000, 32'd1, 32'd1);
      else                   drive(1'b0, 3'b000, 32'd0, 32'd0);
      #1;
      if (!busy_o)  busy_lo++;
      if (valid_o)  valid_hi++;
    end
    check("mul busy c1-32 low count",   busy_lo,  0);
    check("mul valid c1-32 high count", valid_hi, 0);
    check("mul data hidden c32", data_o, 32'hFFF0_FFF0);
    tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    #1;
    check("mul data",  data_o, 32'h0123_4500);
    check("mul valid", {31'd0, valid_o}, 32'd1);
    check("mul zero",  {31'd0, zero_o}, 32'd0);
    check("mul busy c33", {31'd0, busy_o}, 32'd0);
    tick();
    check("mul valid drop", {31'd0, valid_o}, 32'd0);

    // ---- MUL wrap / signed operands ----
    do_mul("mul ffxff", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
    do_mul("mul 8x2",   32'h8000_0000, 32'h0000_0002, 32'h0000_0000);
    do_mul("mul -2x3",  32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFA);

    // ---- Flush mid-MUL in cycle 10 ----
    drive(1'b1, 3'b100, 32'd3, 32'd4);
    tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    repeat (9) tick();
    flush_i = 1'b1;
    #1;
    check("flush busy c10", {31'd0, busy_o}, 32'd1);
    tick();
    flush_i = 1'b0;
    check("flush busy c11",  {31'd0, busy_o}, 32'd0);
    check("flush valid c11", {31'd0, valid_o}, 32'd0);
    check("flush data hold", data_o, 32'hFFFF_FFFA);
    valid_hi = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (valid_o || busy_o) valid_hi++;
    end
    check("flush no late result", valid_hi, 0);
    drive(1'b1, 3'b000, 32'd1, 32'd1);
    tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    check("post-flush add data",  data_o, 32'd2);
    check("post-flush add valid", {31'd0, valid_o}, 32'd1);
    tick();

    // ---- Reset mid-MUL in cycle 10 ----
    drive(1'b1, 3'b100, 32'd3, 32'd4);
    tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    repeat (9) tick();
    rst_i = 1'b0;
    #1;
    check("rstmid data",  data_o, 32'd0);
    check("rstmid zero",  {31'd0, zero_o}, 32'd1);
    check("rstmid valid", {31'd0, valid_o}, 32'd0);
    check("rstmid busy",  {31'd0, busy_o}, 32'd0);
    tick();
    rst_i = 1'b1;
    valid_hi = 0;
    for (int c = 0; c < 30; c++) begin
      tick();
      if (valid_o || busy_o) valid_hi++;
    end
    check("rstmid no late result", valid_hi, 0);

    // ---- Undefined code after a nonzero result ----
    drive(1'b1, 3'b000, 32'd1, 32'd1);
    tick();
    check("pre-undef data", data_o, 32'd2);
    drive(1'b1, 3'b111, 32'h1234_5678, 32'h9ABC_DEF0);
    #1;
    check("undef busy", {31'd0, busy_o}, 32'd0);
    tick();
    drive(1'b0, 3'b000, 32'd0, 32'd0);
    check("undef data",  data_o, 32'd0);
    check("undef zero",  {31'd0, zero_o}, 32'd1);
    check("undef valid", {31'd0, valid_o}, 32'd1);
    check("undef busy after", {31'd0, busy_o}, 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Multi-cycle execute-stage ALU for the 32-bit pipelined CPU; sits directly downstream of ALU control and consumes its 3-bit ALUCtrl code.
- ADD, SUB, AND and OR complete in one cycle.
- MUL runs on an iterative shift-add engine; busy_o stalls the pipeline until the product is ready.
- Result and zero flag are registered for the EX/MEM pipeline register.

Parameters:
- WIDTH, 32, operand and result width; MUL takes WIDTH iterations.

Ports:
- clk_i  input  1  clock, rising edge
- rst_i  input  1  reset, asynchronous, active-low
- start_i  input  1  operation request, qualified with operands and ALUCtrl_i
- flush_i  input  1  aborts any in-flight operation
- ALUCtrl_i  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 MUL, 101-111 undefined
- data1_i  input  WIDTH  operand A
- data2_i  input  WIDTH  operand B
- data_o  output  WIDTH  registered result
- zero_o  output  1  registered (data_o == 0)
- valid_o  output  1  one-cycle pulse marking a new result
- busy_o  output  1  stall request to hazard unit, combinational

Behaviour:
- Reset (rst_i low, asynchronous): state IDLE, data_o=0, zero_o=1, valid_o=0, busy_o=0, counter and internal registers 0.
- States: IDLE, RUN.
- Accept: start_i=1 in IDLE with flush_i=0. start_i in RUN is ignored; the upstream stage must hold while busy_o=1.
- Single-cycle ops (000-011), accepted in cycle N:
  - data_o, zero_o and valid_o=1 appear in cycle N+1.
  - Arithmetic wraps modulo 2^WIDTH. No overflow or carry output.
- Undefined codes (101-111): treated as single-cycle; data_o=0, zero_o=1, valid_o=1 in N+1.
- MUL accepted in cycle N:
  - Latch multiplicand = data1_i and multiplier = data2_i. Clear the accumulator and counter. Go to RUN.
  - Each RUN edge: if multiplier LSB is 1, add the multiplicand to the accumulator (mod 2^WIDTH). Then shift the multiplicand left 1, shift the multiplier right 1, and increment the counter.
  - After WIDTH iterations (the edge ending cycle N+WIDTH), load data_o with the low WIDTH bits of the product and return to IDLE.
  - data_o, zero_o and valid_o=1 appear in cycle N+WIDTH+1.
  - The low bits are identical for signed and unsigned operands, so no sign handling is needed.
- busy_o = (IDLE & start_i & ALUCtrl_i==100 & ~flush_i) | (state==RUN).
  - High from the MUL acceptance cycle N through cycle N+WIDTH. Low in the cycle valid_o rises.
  - A new start_i is accepted in that same cycle.
- valid_o is high for exactly one cycle per accepted operation. It is never high in the cycle after a flush.
- data_o and zero_o hold the last result while valid_o=0. Intermediate accumulator values are never visible on data_o.
- flush_i has priority over start_i:
  - Any flush_i=1 cycle forces state IDLE and valid_o=0 at the next edge and discards the in-flight MUL.
  - data_o and zero_o keep their prior values.
  - A start_i in the same cycle is dropped.
- Reset mid-MUL: immediate return to reset values; no valid_o pulse for the aborted operation.
- Back-to-back single-cycle ops: one result per cycle, valid_o continuously high.

Test Plan:
- Reset then ADD: rst_i low→high, start_i=1, ALUCtrl_i=000, data1_i=5, data2_i=7. Next cycle: data_o=12, valid_o=1, zero_o=0. valid_o=0 the cycle after.
- SUB/AND/OR back-to-back:
  - SUB 7-7 → data_o=0, zero_o=1.
  - SUB 0-1 → data_o=FFFFFFFF.
  - AND F0F0F0F0 & 0FF00FF0 → 00F000F0.
  - OR → FFF0FFF0.
  - Expect valid_o high on 4 consecutive cycles.
- MUL latency: MUL 0x00012345 × 0x00000100 accepted in cycle 0.
  - busy_o high in cycles 0-32.
  - data_o=0x01234500 and valid_o=1 in cycle 33.
  - busy_o=0 in cycle 33.
  - start_i pulses in cycles 5-20 are ignored.
- MUL wrap and signed: FFFFFFFF × FFFFFFFF → 00000001. 80000000 × 2 → 00000000 with zero_o=1. FFFFFFFE × 3 → FFFFFFFA.
- Flush/reset mid-MUL:
  - Start MUL 3×4, assert flush_i in cycle 10 → busy_o=0 from cycle 11, no valid_o, data_o keeps the previous value. Next ADD 1+1 → 2 after 1 cycle.
  - Repeat with rst_i pulsed low in cycle 10 → all outputs at reset values immediately.
- Undefined code: ALUCtrl_i=111 with nonzero operands → data_o=0, zero_o=1, valid_o=1 next cycle, busy_o never asserted.
